i2c_slave_regs: RTL and testbench
=================================

I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'h50, meaning the 7-bit bus address the block responds to.
REQ-002 The block SHALL have parameter CLK_DIV_MIN, default 20, meaning the minimum clk/SCL frequency ratio the block supports (documentation only, no logic).
REQ-003 clk  input  1  system clock; one clock domain; all state on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scl  input  1  bus clock; externally pulled up; the block never drives it.
REQ-006 sda  inout  1  bus data; open-drain; the block drives only 1'b0 or 1'bz; externally pulled up.
REQ-007 regs_q  output  128  register file; byte n at bits [8n+7:8n], for n = 0..15.
REQ-008 wr_strobe  output  1  one-clk pulse per register byte written.
REQ-009 wr_addr  output  4  index of the byte written; valid with wr_strobe.
REQ-010 wr_data  output  8  value of the byte written; valid with wr_strobe.
REQ-011 busy  output  1  high from the block's own address match until STOP or a non-matching START.

Function
REQ-012 scl and sda SHALL pass through 2-flop synchronizers; all edge and level decisions SHALL use the synchronized values only.
REQ-013 START SHALL be detected when synchronized sda falls while synchronized scl is high; STOP when sda rises while scl is high.
REQ-014 Data bits SHALL be sampled on synchronized scl rising edge, MSB first.
REQ-015 sda SHALL change only on synchronized scl falling edge, except for the release on reset or on STOP.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
REQ-017 IDLE -> ADDR on START. ADDR collects 8 bits (7-bit address plus R/W).
REQ-018 On address match -> ADDR_ACK: drive sda low for the 9th bit; set busy.
REQ-019 On address mismatch (including general call 0x00) -> IGNORE without ACK. IGNORE exits only on START or STOP.
REQ-020 After ADDR_ACK with W=0 -> PTR. The 8-bit byte's low 4 bits load ptr; the upper 4 bits are ignored. Then PTR_ACK (ACK driven), then WR.
REQ-021 WR collects a byte. WR_ACK drives ACK, writes regs_q[ptr], pulses wr_strobe with wr_addr=ptr and wr_data=byte, and increments ptr. The strobe occurs on the 8th-bit scl rising edge +1 clk.
REQ-022 After ADDR_ACK with R=1 -> RD: shift out regs_q[ptr] MSB first. A 0 bit drives sda low; a 1 bit releases sda.
REQ-023 RD_ACK: release sda and sample the master's ACK on the 9th scl rise.
REQ-024 After RD_ACK: ACK -> ptr+1, RD. NACK -> IGNORE with sda released.
REQ-025 ptr SHALL wrap 4'hF -> 4'h0 on increment. ptr SHALL persist across STOP and repeated START; it is cleared only by reset.
REQ-026 START in any state (repeated start) SHALL -> ADDR, with sda released and any partial byte discarded.
REQ-027 STOP in any state SHALL -> IDLE with sda released and busy low. A partial byte SHALL NOT be written and SHALL NOT strobe.
REQ-028 A START and STOP cannot coincide; a START seen on the same clk as an scl edge SHALL take priority.
REQ-029 No clock stretching; scl is never driven.

Reset
REQ-030 While reset is high: state=IDLE, sda released (z), regs_q=0, ptr=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0, bit counter=0, and synchronizers=1.
REQ-031 Reset asserted mid-transfer SHALL release sda within the same cycle (asynchronous). After deassertion the block SHALL ignore the bus until the next START.

Verification
REQ-032 Sequence START, 0xA0, 0x03, 0xA5, 0x5A, STOP -> 4 ACKs; regs_q byte3=0xA5, byte4=0x5A; two wr_strobe pulses with (3,0xA5) and (4,0x5A).
REQ-033 Sequence START, 0xA0, 0x03, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP -> master reads 0xA5 then 0x5A; busy is low after STOP.
REQ-034 Sequence START, 0xA2, 0x00, STOP -> sda never driven low by the DUT; no strobe; regs_q unchanged; busy stays 0.
REQ-035 Write at ptr 0x0F with data 0x11, 0x22 -> byte15=0x11, byte0=0x22; wr_addr sequence 15, 0.
REQ-036 Write with STOP after 4 data bits -> no strobe, regs_q unchanged. The next START, 0xA0 is ACKed normally.
REQ-037 Assert reset while the DUT drives an ACK -> sda goes z immediately; regs_q=0. After release, a full write of 0x77 to ptr 0x01 succeeds.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a 16-byte register file. The first byte written after the address sets the pointer;
// each later byte writes regs[ptr]. Reads return regs[ptr]. The pointer auto-increments and wraps at 16.
// state    | meaning
// IDLE     | waiting for START
// ADDR     | shifting in 7-bit address + R/W
// ADDR_ACK | driving ACK for our address
// PTR      | shifting in register pointer byte
// PTR_ACK  | driving ACK for pointer byte
// WR       | shifting in write data byte
// WR_ACK   | driving ACK for written byte
// RD       | shifting out regs[ptr]
// RD_ACK   | sampling master ACK/NACK
// IGNORE   | not addressed; wait for START/STOP
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         CLK_DIV_MIN = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         scl,
  inout  wire          sda,
  output logic [127:0] regs_q,
  output logic         wr_strobe,
  output logic [3:0]   wr_addr,
  output logic [7:0]   wr_data,
  output logic         busy
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] ADDR     = 4'd1;
  localparam logic [3:0] ADDR_ACK = 4'd2;
  localparam logic [3:0] PTR      = 4'd3;
  localparam logic [3:0] PTR_ACK  = 4'd4;
  localparam logic [3:0] WR       = 4'd5;
  localparam logic [3:0] WR_ACK   = 4'd6;
  localparam logic [3:0] RD       = 4'd7;
  localparam logic [3:0] RD_ACK   = 4'd8;
  localparam logic [3:0] IGNORE   = 4'd9;

  // Below this ratio the synchronizer latency eats the scl low phase.
  if (CLK_DIV_MIN < 8) begin : g_div_check
    $error("CLK_DIV_MIN too small for synchronized bus sampling");
  end

  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;
  logic [3:0]   state_q, state_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [6:0]   sh_q, sh_d;
  logic [3:0]   ptr_q, ptr_d;
  logic         rw_q, rw_d;
  logic         sda_oe_q, sda_oe_d;
  logic         busy_q, busy_d;
  logic [127:0] regs_d;
  logic         wr_strobe_q, wr_strobe_d;
  logic [3:0]   wr_addr_q, wr_addr_d;
  logic [7:0]   wr_data_q, wr_data_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_prev_q & sda_s2_q;
  assign rx_byte   = {sh_q, sda_s2_q};
  assign rd_byte   = regs_q[{ptr_q, 3'b000} +: 8];

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WR: if (scl_rise) begin
          sh_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == PTR) begin
              ptr_d   = rx_byte[3:0];
              state_d = PTR_ACK;
            end else begin
              regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = rx_byte;
              ptr_d       = ptr_q + 4'd1;
              state_d     = WR_ACK;
            end
          end
        end
        // First scl fall starts the ACK slot, the second ends it.
        ADDR_ACK, PTR_ACK, WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d  = RD;
              sda_oe_d = ~rd_byte[7];
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WR;
            end
          end
        end
        RD: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RD_ACK;
            end else begin
              sda_oe_d = ~rd_byte[3'd7 - bit_cnt_q[2:0]];
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_s2_q) begin
            ptr_d     = ptr_q + 4'd1;
            bit_cnt_d = 4'd0;
            state_d   = RD;
          end else begin
            state_d = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      sh_q        <= 7'd0;
      ptr_q       <= 4'd0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      regs_q      <= 128'd0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 4'd0;
      wr_data_q   <= 8'd0;
    end else begin
      scl_s1_q    <= scl;
      scl_s2_q    <= scl_s1_q;
      scl_prev_q  <= scl_s2_q;
      sda_s1_q    <= sda;
      sda_s2_q    <= sda_s1_q;
      sda_prev_q  <= sda_s2_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banged master drives the bus, and a scoreboard
// queue holds the expected write strobes.
module tb_i2c_slave_regs;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scl = 1'b1;
  logic         m_oe = 1'b0;
  wire          sda_bus;
  logic [127:0] regs_q;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         busy;

  pullup (sda_bus);
  assign sda_bus = m_oe ? 1'b0 : 1'bz;

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .CLK_DIV_MIN(20)) dut (
    .clk(clk), .reset(rst), .scl(scl), .sda(sda_bus), .regs_q(regs_q),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_regs [16];
  logic [11:0] exp_q [$];
  bit          watch_low = 1'b0;
  int          dut_low = 0;

  always @(negedge clk) begin
    if (watch_low && !m_oe && sda_bus === 1'b0) dut_low++;
  end

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_strobe observed addr=%0h data=%0h expected none", wr_addr, wr_data);
      end
      if (exp_q.size() != 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        vectors++;
        assert ({wr_addr, wr_data} === e) else begin
          miscompares++;
          $error("FAIL strobe observed=%0h expected=%0h", {wr_addr, wr_data}, e);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] packed_regs();
    logic [127:0] p;
    for (int i = 0; i < 16; i++) p[i*8 +: 8] = exp_regs[i];
    return p;
  endfunction

  task automatic wq();
    repeat (10) @(posedge clk);
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      wq(); m_oe = 1'b0; wq(); scl = 1'b1; wq();
    end else begin
      m_oe = 1'b0; wq();
    end
    m_oe = 1'b1; wq(); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wq(); m_oe = 1'b1; wq(); scl = 1'b1; wq(); m_oe = 1'b0; wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wq(); m_oe = ~b[7-i]; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0;
    end
  endtask

  task automatic get_ack(output logic a);
    wq(); m_oe = 1'b0; wq(); scl = 1'b1; wq(); a = sda_bus; wq(); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    get_ack(a);
  endtask

  task automatic write_data(input logic [3:0] ptr, input logic [7:0] b, output logic a);
    exp_q.push_back({ptr, b});
    exp_regs[ptr] = b;
    write_byte(b, a);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    m_oe = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wq(); wq(); scl = 1'b1; wq(); d = {d[6:0], sda_bus}; wq(); scl = 1'b0;
    end
    wq(); m_oe = ack; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq(); m_oe = 1'b0;
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    check("rst_regs", regs_q, 128'd0);
    check("rst_busy", busy, 0);
    check("rst_strobe", wr_strobe, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_sda", sda_bus, 1);
    rst = 1'b0;
    wq();

    // Two-byte write at pointer 3.
    i2c_start();
    write_byte(8'hA0, a);        check("w1_addr_ack", a, 0);
    check("w1_busy", busy, 1);
    write_byte(8'h03, a);        check("w1_ptr_ack", a, 0);
    write_data(4'h3, 8'hA5, a);  check("w1_d0_ack", a, 0);
    write_data(4'h4, 8'h5A, a);  check("w1_d1_ack", a, 0);
    i2c_stop();
    check("w1_regs", regs_q, packed_regs());
    check("w1_busy_after_stop", busy, 0);

    // Set pointer, repeated start, read two bytes.
    i2c_start();
    write_byte(8'hA0, a);        check("r1_addr_ack", a, 0);
    write_byte(8'h03, a);        check("r1_ptr_ack", a, 0);
    i2c_start();
    write_byte(8'hA1, a);        check("r1_raddr_ack", a, 0);
    read_byte(1'b1, d);          check("r1_byte0", d, 8'hA5);
    read_byte(1'b0, d);          check("r1_byte1", d, 8'h5A);
    i2c_stop();
    check("r1_busy_after_stop", busy, 0);
    check("r1_regs", regs_q, packed_regs());

    // Foreign address and general call are never acknowledged.
    dut_low = 0;
    watch_low = 1'b1;
    i2c_start();
    write_byte(8'hA2, a);        check("nm_addr_nack", a, 1);
    check("nm_busy", busy, 0);
    write_byte(8'h00, a);        check("nm_data_nack", a, 1);
    i2c_stop();
    i2c_start();
    write_byte(8'h00, a);        check("gc_nack", a, 1);
    i2c_stop();
    watch_low = 1'b0;
    check("nm_dut_low_cycles", dut_low, 0);
    check("nm_regs", regs_q, packed_regs());
    check("nm_busy_after", busy, 0);

    // Pointer wraps from 15 to 0.
    i2c_start();
    write_byte(8'hA0, a);        check("wrap_addr_ack", a, 0);
    write_byte(8'h0F, a);        check("wrap_ptr_ack", a, 0);
    write_data(4'hF, 8'h11, a);  check("wrap_d0_ack", a, 0);
    write_data(4'h0, 8'h22, a);  check("wrap_d1_ack", a, 0);
    i2c_stop();
    check("wrap_regs", regs_q, packed_regs());

    // STOP after a partial byte must not write.
    i2c_start();
    write_byte(8'hA0, a);        check("part_addr_ack", a, 0);
    write_byte(8'h02, a);        check("part_ptr_ack", a, 0);
    send_bits(8'hC3, 4);
    i2c_stop();
    check("part_regs", regs_q, packed_regs());
    i2c_start();
    write_byte(8'hA0, a);        check("part_next_ack", a, 0);
    i2c_stop();

    // Reset while the DUT holds an ACK.
    i2c_start();
    send_bits(8'hA0, 8);
    wq(); m_oe = 1'b0; wq();
    check("rst_mid_ack_low", sda_bus, 0);
    rst = 1'b1;
    #1;
    check("rst_mid_sda_release", sda_bus, 1);
    check("rst_mid_regs", regs_q, 128'd0);
    check("rst_mid_busy", busy, 0);
    for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
    scl = 1'b1;
    wq();
    rst = 1'b0;
    wq();
    i2c_start();
    write_byte(8'hA0, a);        check("post_rst_addr_ack", a, 0);
    write_byte(8'h01, a);        check("post_rst_ptr_ack", a, 0);
    write_data(4'h1, 8'h77, a);  check("post_rst_d_ack", a, 0);
    i2c_stop();
    check("post_rst_regs", regs_q, packed_regs());
    wq();
    check("strobes_outstanding", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
